// File: rtl/task_4_pkg.sv
// Shared types and defaults for the task_4 stream arbiter.
package task_4_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FWD       = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_t;

  typedef logic ch_id_t;

  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_CNT_W          = 16;

endpackage

// File: rtl/task_4_arb_timeout.sv
// WAIT_DONE watchdog counter; only instantiated when TASK_4_ARB_TIMEOUT_EN is defined.
module task_4_arb_timeout #(
  parameter int CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expire = enable && (cnt == W'(CYCLES - 1));

endmodule

// File: rtl/task_4_stream_arb.sv
// Packet-locked two-channel round-robin arbiter feeding the task_4 pipeline.
// Optional WAIT_DONE watchdog enabled by defining TASK_4_ARB_TIMEOUT_EN.
module task_4_stream_arb
  import task_4_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ch0_tdata_valid,
  input  logic [7:0]       i_ch0_tdata,
  input  logic             i_ch0_tdata_last,
  output logic             o_ch0_tready,
  input  logic             i_ch1_tdata_valid,
  input  logic [7:0]       i_ch1_tdata,
  input  logic             i_ch1_tdata_last,
  output logic             o_ch1_tready,
  output logic             o_tdata_valid,
  output logic [7:0]       o_tdata,
  output logic             o_tdata_last,
  input  logic             i_tready,
  input  logic             i_done,
  output logic             o_grant,
  output logic             o_busy,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_pkt_cnt
);

  arb_state_t       state, state_next;
  ch_id_t           grant_reg, last_reg, pick;
  logic [CNT_W-1:0] pkt_cnt_reg;
  logic             fwd, any_valid, sel_valid, sel_last, last_hs, expire;
  logic [7:0]       sel_data;

  assign fwd       = (state == FWD);
  assign any_valid = i_ch0_tdata_valid | i_ch1_tdata_valid;
  assign sel_valid = grant_reg ? i_ch1_tdata_valid : i_ch0_tdata_valid;
  assign sel_data  = grant_reg ? i_ch1_tdata       : i_ch0_tdata;
  assign sel_last  = grant_reg ? i_ch1_tdata_last  : i_ch0_tdata_last;
  assign last_hs   = fwd && sel_valid && i_tready && sel_last;

  // On a tie the channel that did not finish the previous packet wins.
  assign pick = (i_ch0_tdata_valid && i_ch1_tdata_valid) ? ~last_reg :
                (i_ch0_tdata_valid ? 1'b0 : 1'b1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (any_valid)        state_next = FWD;
      FWD:       if (last_hs)          state_next = WAIT_DONE;
      WAIT_DONE: if (i_done || expire) state_next = IDLE;
      default:                         state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      grant_reg   <= 1'b1;
      last_reg    <= 1'b1;
      pkt_cnt_reg <= '0;
    end else begin
      if (state == IDLE && any_valid) begin
        grant_reg <= pick;
      end
      if (last_hs) begin
        last_reg    <= grant_reg;
        pkt_cnt_reg <= pkt_cnt_reg + CNT_W'(1);
      end
    end
  end

`ifdef TASK_4_ARB_TIMEOUT_EN
  logic timeout_reg;

  task_4_arb_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (i_clk),
    .rst    (i_rst),
    .enable (state == WAIT_DONE),
    .clear  (last_hs),
    .expire (expire)
  );

  // A coincident i_done takes the normal exit, so no pulse is raised.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= (state == WAIT_DONE) && expire && !i_done;
    end
  end

  assign o_timeout = timeout_reg;
`else
  assign expire    = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // Zero-latency pass-through; data and last are forced low when not valid.
  assign o_tdata_valid = fwd & sel_valid;
  assign o_tdata       = o_tdata_valid ? sel_data : 8'h00;
  assign o_tdata_last  = o_tdata_valid & sel_last;
  assign o_ch0_tready  = fwd & ~grant_reg & i_tready;
  assign o_ch1_tready  = fwd &  grant_reg & i_tready;
  assign o_grant       = grant_reg;
  assign o_busy        = (state != IDLE);
  assign o_pkt_cnt     = pkt_cnt_reg;

endmodule

// File: tb/tb_task_4_stream_arb.sv
// Table-driven check of task_4_stream_arb plus hand sequences for wait/timeout and reset.
module tb_task_4_stream_arb;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        c0v, c0l, c1v, c1l, rdy, done;
  logic [7:0]  c0d, c1d;
  logic        o_ch0_tready, o_ch1_tready, o_tdata_valid, o_tdata_last;
  logic        o_grant, o_busy, o_timeout;
  logic [7:0]  o_tdata;
  logic [15:0] o_pkt_cnt;

  int checks = 0;
  int fails  = 0;

  always #5 i_clk = ~i_clk;

  task_4_stream_arb #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_ch0_tdata_valid(c0v), .i_ch0_tdata(c0d), .i_ch0_tdata_last(c0l), .o_ch0_tready(o_ch0_tready),
    .i_ch1_tdata_valid(c1v), .i_ch1_tdata(c1d), .i_ch1_tdata_last(c1l), .o_ch1_tready(o_ch1_tready),
    .o_tdata_valid(o_tdata_valid), .o_tdata(o_tdata), .o_tdata_last(o_tdata_last),
    .i_tready(rdy), .i_done(done), .o_grant(o_grant), .o_busy(o_busy),
    .o_timeout(o_timeout), .o_pkt_cnt(o_pkt_cnt)
  );

  typedef struct {
    logic c0v; logic [7:0] c0d; logic c0l;
    logic c1v; logic [7:0] c1d; logic c1l;
    logic rdy; logic done;
    logic e0r; logic e1r; logic ev; logic [7:0] ed; logic el;
    logic eg; logic eb; logic [15:0] ecnt;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] got1[$];

  function automatic vec_t mk(logic a0v, logic [7:0] a0d, logic a0l,
                              logic a1v, logic [7:0] a1d, logic a1l,
                              logic ar, logic ad,
                              logic x0r, logic x1r, logic xv, logic [7:0] xd, logic xl,
                              logic xg, logic xb, logic [15:0] xc);
    vec_t v;
    v.c0v = a0v; v.c0d = a0d; v.c0l = a0l; v.c1v = a1v; v.c1d = a1d; v.c1l = a1l;
    v.rdy = ar; v.done = ad;
    v.e0r = x0r; v.e1r = x1r; v.ev = xv; v.ed = xd; v.el = xl;
    v.eg = xg; v.eb = xb; v.ecnt = xc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic a0v, input logic [7:0] a0d, input logic a0l,
                       input logic a1v, input logic [7:0] a1d, input logic a1l,
                       input logic ar, input logic ad);
    c0v = a0v; c0d = a0d; c0l = a0l; c1v = a1v; c1d = a1d; c1l = a1l; rdy = ar; done = ad;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".ch0_tready"}, o_ch0_tready, 0);
    chk({tag, ".ch1_tready"}, o_ch1_tready, 0);
    chk({tag, ".tdata_valid"}, o_tdata_valid, 0);
    chk({tag, ".tdata"}, o_tdata, 0);
    chk({tag, ".tdata_last"}, o_tdata_last, 0);
    chk({tag, ".grant"}, o_grant, 1);
    chk({tag, ".busy"}, o_busy, 0);
    chk({tag, ".timeout"}, o_timeout, 0);
    chk({tag, ".pkt_cnt"}, o_pkt_cnt, 0);
  endtask

  initial begin
    int to_seen;
    int to_at;
    // Round-robin ties, alternation, then a ch1 packet with toggling ready and ignored i_done in FWD.
    vecs.push_back(mk(1,8'hA0,1, 1,8'hB0,1, 1,0, 0,0,0,8'h00,0, 1,0,0));
    vecs.push_back(mk(1,8'hA0,1, 1,8'hB0,1, 1,0, 1,0,1,8'hA0,1, 0,1,0));
    vecs.push_back(mk(0,8'h00,0, 1,8'hB0,1, 1,0, 0,0,0,8'h00,0, 0,1,1));
    vecs.push_back(mk(0,8'h00,0, 1,8'hB0,1, 1,1, 0,0,0,8'h00,0, 0,1,1));
    vecs.push_back(mk(0,8'h00,0, 1,8'hB0,1, 1,0, 0,0,0,8'h00,0, 0,0,1));
    vecs.push_back(mk(0,8'h00,0, 1,8'hB0,1, 1,0, 0,1,1,8'hB0,1, 1,1,1));
    vecs.push_back(mk(1,8'hA1,1, 1,8'hB1,1, 1,0, 0,0,0,8'h00,0, 1,1,2));
    vecs.push_back(mk(1,8'hA1,1, 1,8'hB1,1, 1,1, 0,0,0,8'h00,0, 1,1,2));
    vecs.push_back(mk(1,8'hA1,1, 1,8'hB1,1, 1,0, 0,0,0,8'h00,0, 1,0,2));
    vecs.push_back(mk(1,8'hA1,1, 1,8'hB1,1, 1,0, 1,0,1,8'hA1,1, 0,1,2));
    vecs.push_back(mk(0,8'h00,0, 1,8'hB1,1, 1,0, 0,0,0,8'h00,0, 0,1,3));
    vecs.push_back(mk(0,8'h00,0, 1,8'hB1,1, 1,1, 0,0,0,8'h00,0, 0,1,3));
    vecs.push_back(mk(1,8'hEE,1, 1,8'hC0,0, 1,0, 0,0,0,8'h00,0, 0,0,3));
    vecs.push_back(mk(1,8'hEE,1, 1,8'hC0,0, 1,0, 0,1,1,8'hC0,0, 1,1,3));
    vecs.push_back(mk(1,8'hEE,1, 1,8'hC1,0, 0,1, 0,0,1,8'hC1,0, 1,1,3));
    vecs.push_back(mk(1,8'hEE,1, 1,8'hC1,0, 1,0, 0,1,1,8'hC1,0, 1,1,3));
    vecs.push_back(mk(1,8'hEE,1, 0,8'hC2,1, 1,0, 0,1,0,8'h00,0, 1,1,3));
    vecs.push_back(mk(1,8'hEE,1, 1,8'hC2,0, 0,1, 0,0,1,8'hC2,0, 1,1,3));
    vecs.push_back(mk(1,8'hEE,1, 1,8'hC2,0, 1,0, 0,1,1,8'hC2,0, 1,1,3));
    vecs.push_back(mk(1,8'hEE,1, 1,8'hC3,1, 0,0, 0,0,1,8'hC3,1, 1,1,3));
    vecs.push_back(mk(1,8'hEE,1, 1,8'hC3,1, 1,0, 0,1,1,8'hC3,1, 1,1,3));
    vecs.push_back(mk(1,8'hEE,1, 0,8'h00,0, 1,0, 0,0,0,8'h00,0, 1,1,4));
    vecs.push_back(mk(1,8'hEE,1, 0,8'h00,0, 1,0, 0,0,0,8'h00,0, 1,1,4));
    vecs.push_back(mk(1,8'hEE,1, 0,8'h00,0, 1,1, 0,0,0,8'h00,0, 1,1,4));
    vecs.push_back(mk(1,8'hEE,1, 0,8'h00,0, 1,0, 0,0,0,8'h00,0, 1,0,4));
    vecs.push_back(mk(1,8'hEE,1, 0,8'h00,0, 1,0, 1,0,1,8'hEE,1, 0,1,4));

    i_rst = 1'b1;
    drive(0,0,0, 0,0,0, 0,0);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk_reset_outs("reset");
    i_rst = 1'b0;

    foreach (vecs[i]) begin
      @(posedge i_clk); #1;
      drive(vecs[i].c0v, vecs[i].c0d, vecs[i].c0l, vecs[i].c1v, vecs[i].c1d, vecs[i].c1l,
            vecs[i].rdy, vecs[i].done);
      @(negedge i_clk);
      chk($sformatf("v%0d.ch0_tready", i), o_ch0_tready, vecs[i].e0r);
      chk($sformatf("v%0d.ch1_tready", i), o_ch1_tready, vecs[i].e1r);
      chk($sformatf("v%0d.tdata_valid", i), o_tdata_valid, vecs[i].ev);
      chk($sformatf("v%0d.tdata", i), o_tdata, vecs[i].ed);
      chk($sformatf("v%0d.tdata_last", i), o_tdata_last, vecs[i].el);
      chk($sformatf("v%0d.grant", i), o_grant, vecs[i].eg);
      chk($sformatf("v%0d.busy", i), o_busy, vecs[i].eb);
      chk($sformatf("v%0d.pkt_cnt", i), o_pkt_cnt, vecs[i].ecnt);
      if (o_tdata_valid && rdy && o_ch1_tready) got1.push_back(o_tdata);
    end

    chk("ch1_bytes.count", got1.size(), 5);
    if (got1.size() == 5) begin
      chk("ch1_bytes.b0", got1[0], 8'hB0);
      chk("ch1_bytes.b1", got1[1], 8'hC0);
      chk("ch1_bytes.b2", got1[2], 8'hC1);
      chk("ch1_bytes.b3", got1[3], 8'hC2);
      chk("ch1_bytes.b4", got1[4], 8'hC3);
    end

    // The block now sits in WAIT_DONE with no i_done coming.
    to_seen = 0;
    to_at   = -1;
`ifdef TASK_4_ARB_TIMEOUT_EN
    for (int k = 0; k < 20; k++) begin
      @(posedge i_clk); #1;
      drive(0,0,0, 0,0,0, 1,0);
      @(negedge i_clk);
      if (o_timeout) begin
        to_seen++;
        if (to_at < 0) to_at = k;
      end
    end
    chk("timeout.pulses", to_seen, 1);
    chk("timeout.cycle", to_at, 8);
    chk("timeout.busy_after", o_busy, 0);
`else
    for (int k = 0; k < 100; k++) begin
      @(posedge i_clk); #1;
      drive(0,0,0, 0,0,0, 1,0);
      @(negedge i_clk);
      if (o_timeout) to_seen++;
    end
    chk("nowait.timeout_pulses", to_seen, 0);
    chk("nowait.busy_after_100", o_busy, 1);
    @(posedge i_clk); #1;
    drive(0,0,0, 0,0,0, 1,1);
    @(posedge i_clk); #1;
    drive(0,0,0, 0,0,0, 1,0);
    @(negedge i_clk);
    chk("nowait.busy_after_done", o_busy, 0);
`endif

    // Reset in the middle of a 4-byte ch0 packet, after two bytes have moved.
    @(posedge i_clk); #1;
    drive(1,8'h51,0, 0,0,0, 1,0);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("rst_seq.byte1", o_tdata, 8'h51);
    @(posedge i_clk); #1;
    drive(1,8'h52,0, 0,0,0, 1,0);
    @(posedge i_clk); #1;
    drive(1,8'h53,0, 0,0,0, 1,0);
    #1;
    chk("rst_seq.pre_valid", o_tdata_valid, 1);
    i_rst = 1'b1;
    #1;
    chk_reset_outs("rst_async");
    @(negedge i_clk);
    i_rst = 1'b0;
    drive(0,0,0, 1,8'h61,1, 1,0);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("post_rst.grant", o_grant, 1);
    chk("post_rst.tdata_valid", o_tdata_valid, 1);
    chk("post_rst.tdata", o_tdata, 8'h61);
    chk("post_rst.ch1_tready", o_ch1_tready, 1);
    chk("post_rst.ch0_tready", o_ch0_tready, 0);
    @(posedge i_clk); #1;
    drive(0,0,0, 0,0,0, 1,0);
    @(negedge i_clk);
    chk("post_rst.pkt_cnt", o_pkt_cnt, 1);
    chk("post_rst.busy", o_busy, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
